axi_revision_poller: RTL
========================

AXI_REVISION_POLLER -- requirements
Module: axi_revision_poller

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 1024, max cycles waited on a single AR or R handshake before abort.
REQ-002 SHALL have port AXI_ACLK  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port AXI_ARESETN  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start  in  1  single-cycle scan request.
REQ-005 SHALL have ports busy  out  1  (scan in progress), done  out  1  (one-cycle pulse at scan end), error  out  1  (sticky fault flag).
REQ-006 SHALL have AXI4-Lite read-master ports M_AXI_ARADDR out 7, M_AXI_ARVALID out 1, M_AXI_ARPROT out 3, M_AXI_ARREADY in 1.
REQ-007 SHALL have ports M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.
REQ-008 SHALL have output ports word_index out 4, word_data out 32, word_valid out 1, and input word_ready in 1 (valid/ready stream of captured words).

Function
REQ-009 SHALL read 13 registers per scan, index 0..12; address = idx*4 for idx 0..7 (0x00..0x1C), 0x40+(idx-8)*4 for idx 8..12 (0x40..0x50).
REQ-010 SHALL implement FSM states IDLE, ADDR, DATA, EMIT, FINISH.
REQ-011 IDLE: on start=1 -> idx=0, busy=1, error cleared, go ADDR next cycle; start while busy SHALL be ignored.
REQ-012 ADDR: ARVALID=1, ARADDR held stable until AR handshake (ARVALID&ARREADY); then ARVALID=0 and go DATA.
REQ-013 DATA: RREADY=1 until R handshake; then capture RDATA into word_data, idx into word_index, RREADY=0, go EMIT.
REQ-014 RRESP!=0 at R handshake SHALL set error; the word SHALL still be emitted and scan continues.
REQ-015 EMIT: word_valid=1, word_data/word_index stable until word_ready=1; then idx 12 -> FINISH, else idx+1 -> ADDR.
REQ-016 FINISH: done=1 for exactly one cycle, busy=0 same cycle, then IDLE.
REQ-017 Minimum latency per word with zero-wait slave and sink SHALL be 3 cycles (ADDR, DATA, EMIT); full scan 13*3+1 = 40 cycles after start.
REQ-018 A cycle counter SHALL reset on entry to ADDR and DATA; reaching TIMEOUT_CYCLES in either state SHALL set error, drop ARVALID/RREADY, pulse done, return IDLE (abort).
REQ-019 M_AXI_ARPROT SHALL be constant 0; word_index SHALL never exceed 12.
REQ-020 error SHALL remain set until next accepted start or reset.

Reset
REQ-021 Asserting AXI_ARESETN low SHALL immediately force IDLE, idx=0, and outputs busy=0, done=0, error=0, ARVALID=0, RREADY=0, word_valid=0, ARADDR=0, word_index=0, word_data=0.
REQ-022 Reset mid-scan SHALL abandon the scan with no done pulse; no state survives.

Configuration
REQ-023 Macro REVPOLL_AUTOSTART_EN defined: an internal start SHALL fire exactly once, first clock after AXI_ARESETN deasserts, identical to start=1.
REQ-024 Macro undefined: scans begin only on external start.

Verification
REQ-025 Zero-wait slave returns 0x100+idx, word_ready=1, start pulse -> 13 words, index 0..12, data 0x100..0x10C, ARADDR sequence 0x00..0x1C,0x40..0x50, done at cycle 40, error=0.
REQ-026 Slave delays ARREADY 5 cycles and RVALID 7 cycles on idx 3 -> ARADDR 0x0C and ARVALID held stable throughout, word 3 delivered correctly, no duplicate reads.
REQ-027 RRESP=2 on idx 9 (0x44) -> error=1 from that cycle, all 13 words still emitted, done pulses, error held until next start then cleared.
REQ-028 TIMEOUT_CYCLES=16, ARREADY never asserted on idx 0 -> error=1 and done pulse on 16th wait cycle, ARVALID=0, busy=0, zero words emitted.
REQ-029 word_ready held low 20 cycles on idx 5, start pulsed meanwhile -> word_valid/data stable 20 cycles, second start ignored, one scan total.
REQ-030 AXI_ARESETN low during DATA of idx 7 -> all outputs zero same cycle, no done; with REVPOLL_AUTOSTART_EN new scan begins from idx 0 after release.

Source files
------------

// File: rtl/axi_revision_poller_if.sv
// axi_revision_poller_if: AXI4-Lite read-address and read-data channels between poller and slave.
interface axi_revision_poller_if;
  logic [6:0]  M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  modport master (
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_revision_poller.sv
// axi_revision_poller: reads 13 revision registers over AXI4-Lite per scan and streams them out.
// Define REVPOLL_AUTOSTART_EN to launch one scan automatically right after reset release.
module axi_revision_poller #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESETN,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  axi_revision_poller_if.master m_axi,
  output logic [3:0]            word_index,
  output logic [31:0]           word_data,
  output logic                  word_valid,
  input  logic                  word_ready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, EMIT, FINISH} state_t;
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_d;
  logic [3:0]    word_index_q, word_index_d;
  logic [31:0]   word_data_q, word_data_d;
  logic          start_i, timeout, last;
`ifdef REVPOLL_AUTOSTART_EN
  logic auto_q;
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
    if (!AXI_ARESETN) auto_q <= 1'b1;
    else auto_q <= 1'b0;
  assign start_i = start | auto_q;
`else
  assign start_i = start;
`endif
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign last    = idx_q == 4'd12;
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
    word_index_d = word_index_q;
    word_data_d  = word_data_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = ADDR;
        idx_d   = 4'd0;
        cnt_d   = '0;
        error_d = 1'b0;
      end
      ADDR: begin
        cnt_d = cnt_q + 1'b1;
        if (m_axi.M_AXI_ARREADY) begin
          state_d = DATA;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = FINISH;
          error_d = 1'b1;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (m_axi.M_AXI_RVALID) begin
          state_d      = EMIT;
          word_data_d  = m_axi.M_AXI_RDATA;
          word_index_d = idx_q;
          error_d      = error_q | (|m_axi.M_AXI_RRESP);
        end else if (timeout) begin
          state_d = FINISH;
          error_d = 1'b1;
        end
      end
      EMIT: if (word_ready) begin
        state_d = last ? FINISH : ADDR;
        idx_d   = last ? idx_q : idx_q + 4'd1;
        cnt_d   = '0;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
    if (!AXI_ARESETN) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      cnt_q        <= '0;
      error_q      <= 1'b0;
      word_index_q <= 4'd0;
      word_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
      word_index_q <= word_index_d;
      word_data_q  <= word_data_d;
    end
  // Indices 8..12 live in a second bank at 0x40, so bit 3 of idx becomes address bit 6.
  assign m_axi.M_AXI_ARADDR  = {idx_q[3], 1'b0, idx_q[2:0], 2'b00};
  assign m_axi.M_AXI_ARVALID = state_q == ADDR;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_RREADY  = state_q == DATA;
  assign busy       = state_q inside {ADDR, DATA, EMIT};
  assign done       = state_q == FINISH;
  assign error      = error_q;
  assign word_valid = state_q == EMIT;
  assign word_index = word_index_q;
  assign word_data  = word_data_q;
endmodule
